// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory (1-cycle read latency)
//            between the instruction-fetch port and the load/store data port.
//            At most one access is granted per cycle. The data port wins ties,
//            but a fetch that has lost MAX_WAIT times in a row is forced
//            through. Read data is routed back to whichever port issued the read.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            if_req/if_addr/if_gnt           - fetch request side
//            if_rvalid/if_rdata              - fetch response side
//            d_req/d_we/d_be/d_addr/d_wdata  - data request side
//            d_gnt/d_rvalid/d_rdata          - data grant / load response
//            mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata - memory side
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    // Response owner encoding
    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_IF   = 2'd1;
    localparam logic [1:0] S_D    = 2'd2;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic [1:0]        r_rsp_owner;
    logic [1:0]        w_rsp_owner_nxt;
    logic              w_starved;
    logic              w_if_arb;
    logic              w_d_arb;
    logic              w_if_gnt;
    logic              w_d_gnt;

    // Arbitration. w_*_arb drive internal state; the reset-gated w_*_gnt
    // copies drive the ports so every output reads 0 while rst_n is low,
    // without putting the async reset onto any flop data path.
    assign w_starved = (r_wait_cnt == C_MAX_WAIT);
    assign w_if_arb  = if_req & (~d_req | w_starved);
    assign w_d_arb   = d_req & ~w_if_arb;
    assign w_if_gnt  = rst_n & w_if_arb;
    assign w_d_gnt   = rst_n & w_d_arb;

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    // Memory request mux; idle cycles drive every mem_* output to 0.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : '0;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Consecutive cycles a pending fetch has been passed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (if_req && !w_if_arb) begin
            if (!w_starved) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Response FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_owner <= S_NONE;
        end else begin
            r_rsp_owner <= w_rsp_owner_nxt;
        end
    end

    // Response FSM: next state (memory answers one cycle after a read grant)
    always_comb begin
        w_rsp_owner_nxt = S_NONE;
        if (w_if_arb) begin
            w_rsp_owner_nxt = S_IF;
        end else if (w_d_arb && !d_we) begin
            w_rsp_owner_nxt = S_D;
        end
    end

    // Response FSM: outputs
    always_comb begin
        if_rvalid = (r_rsp_owner == S_IF);
        d_rvalid  = (r_rsp_owner == S_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Provides a 256-word
//            synchronous memory behind the arbiter and a transaction-level
//            reference model (loss counter, pending-response owner, shadow
//            memory) used by the randomized scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int DW       = 32;
    localparam int AW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b ^ 8'hA0, b, 8'h5C, ~b};
    endfunction

    // Memory behind the arbiter
    logic [31:0] env_mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= env_mem[mem_addr[9:2]];
            end
        end
    end

    // Reference model: who should win this cycle, who owns next cycle's
    // response and what data it carries.
    logic [31:0] ref_mem [0:255];
    int          m_wait;
    int          m_owner;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_rdata;
    logic        exp_if_gnt;
    logic        exp_d_gnt;

    assign exp_if_gnt = rst_n && if_req && (!d_req || m_wait == MAX_WAIT);
    assign exp_d_gnt  = rst_n && d_req && !exp_if_gnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait  <= 0;
            m_owner <= 0;
            m_rdata <= '0;
        end else begin
            if (exp_if_gnt) begin
                m_owner <= 1;
                m_rdata <= ref_mem[if_addr[9:2]];
            end else if (exp_d_gnt && !d_we) begin
                m_owner <= 2;
                m_rdata <= ref_mem[d_addr[9:2]];
            end else begin
                m_owner <= 0;
            end
            if (exp_d_gnt && d_we)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] <= d_wdata[8*b +: 8];
            if (if_req && !exp_if_gnt)
                m_wait <= (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else
                m_wait <= 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h48; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0 || mem_be !== 4'h0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b%b en=%b we=%b be=%h addr=%h wdata=%h rv=%b%b exp all 0",
                     if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rvalid, d_rvalid);
        end
        if_req = 1'b0; d_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_fetch();
        env_mem[4] = 32'h00500093;
        ref_mem[4] = 32'h00500093;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
            mem_be !== 4'h0 || mem_addr !== 32'h10 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL fetch_grant gnt=%b%b en=%b we=%b be=%h addr=%h exp gnt=10 en=1 we=0 be=0 addr=10",
                     if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_rsp rvalid=%b rdata=%h exp 1 00500093", if_rvalid, if_rdata);
        end
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL fetch_no_drsp d_rvalid=%b d_rdata=%h exp 0 0", d_rvalid, d_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== '0) begin
            errors++;
            $display("FAIL fetch_rsp_end rvalid=%b rdata=%h exp 0 0", if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_store();
        logic [31:0] w;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h104; d_wdata = 32'h0000A5A5;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_be !== 4'b0011 || mem_addr !== 32'h104 || mem_wdata !== 32'h0000A5A5) begin
            errors++;
            $display("FAIL store_grant gnt=%b%b we=%b be=%b addr=%h wdata=%h exp gnt=01 we=1 be=0011 addr=104 wdata=a5a5",
                     if_gnt, d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rsp d_rvalid=%b if_rvalid=%b exp 0 0", d_rvalid, if_rvalid);
        end
        w = init_word(32'h41);
        checks++;
        if (env_mem[32'h41] !== {w[31:16], 16'hA5A5}) begin
            errors++;
            $display("FAIL store_data mem=%h exp %h", env_mem[32'h41], {w[31:16], 16'hA5A5});
        end
        next_cycle();
    endtask

    // Both ports hammer continuously: every (MAX_WAIT+1)th grant is a fetch.
    task automatic test_priority_pattern();
        logic exp_if, prev_if;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            exp_if = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            checks++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                errors++;
                $display("FAIL pattern_gnt k=%0d gnt=%b%b exp %b%b", k, if_gnt, d_gnt, exp_if, !exp_if);
            end
            if (k > 0) begin
                prev_if = (((k - 1) % (MAX_WAIT + 1)) == MAX_WAIT);
                checks++;
                if (if_rvalid !== prev_if || d_rvalid !== !prev_if ||
                    (prev_if  && if_rdata !== init_word(8)) ||
                    (!prev_if && d_rdata  !== init_word(16))) begin
                    errors++;
                    $display("FAIL pattern_rsp k=%0d rv=%b%b if_rdata=%h d_rdata=%h exp rv=%b%b",
                             k, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_if, !prev_if);
                end
            end
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            if_req  = (k < 3);
            if_addr = 32'(4 * k);
            @(negedge clk);
            if (k < 3) begin
                checks++;
                if (if_gnt !== 1'b1 || mem_addr !== 32'(4 * k)) begin
                    errors++;
                    $display("FAIL b2b_gnt k=%0d gnt=%b addr=%h exp 1 %h", k, if_gnt, mem_addr, 4 * k);
                end
            end
            if (k > 0) begin
                checks++;
                if (k < 4 ? (if_rvalid !== 1'b1 || if_rdata !== init_word(k - 1))
                          : (if_rvalid !== 1'b0)) begin
                    errors++;
                    $display("FAIL b2b_rsp k=%0d rvalid=%b rdata=%h exp %b %h",
                             k, if_rvalid, if_rdata, k < 4, k < 4 ? init_word(k - 1) : 32'h0);
                end
            end
            next_cycle();
        end
        idle(1);
    endtask

    // Reset lands while a load response is pending and the fetch has
    // already lost several times.
    task automatic test_reset_mid();
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d d_gnt=%b exp 1", k, d_gnt);
            end
            next_cycle();
        end
        d_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0 || mem_addr !== '0 ||
            if_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs gnt=%b%b en=%b rv=%b%b d_rdata=%h exp all 0",
                     if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, d_rdata);
        end
        next_cycle();
        next_cycle();
        if_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_rsp rv=%b%b exp 00", if_rvalid, d_rvalid);
        end
        next_cycle();
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < MAX_WAIT + 1; k++) begin
            @(negedge clk);
            exp_if = (k == MAX_WAIT);
            checks++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                errors++;
                $display("FAIL rstmid_wait k=%0d gnt=%b%b exp %b%b", k, if_gnt, d_gnt, exp_if, !exp_if);
            end
            next_cycle();
        end
        idle(2);
    endtask

    // Data request withdrawn while the fetch is being forced through.
    task automatic test_withdraw();
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h90;
        for (int k = 0; k < MAX_WAIT; k++) next_cycle();
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h30) begin
            errors++;
            $display("FAIL withdraw_forced gnt=%b%b we=%b addr=%h exp 10 0 30", if_gnt, d_gnt, mem_we, mem_addr);
        end
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || d_gnt !== 1'b0 || if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle en=%b d_gnt=%b rv=%b%b exp 0 0 10", mem_en, d_gnt, if_rvalid, d_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_no_drsp d_rvalid=%b exp 0", d_rvalid);
        end
        next_cycle();
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < MAX_WAIT + 1; k++) begin
            @(negedge clk);
            exp_if = (k == MAX_WAIT);
            checks++;
            if (if_gnt !== exp_if) begin
                errors++;
                $display("FAIL withdraw_wait_clr k=%0d if_gnt=%b exp %b", k, if_gnt, exp_if);
            end
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_random();
        logic          g_if, g_d;
        logic          e_en, e_we;
        logic [3:0]    e_be;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_ird, e_drd;
        g_if = 1'b0; g_d = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = {22'd0, 8'($urandom), 2'b00};
            end else if ($urandom_range(0, 7) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = 4'($urandom);
                d_addr  = {22'd0, 8'($urandom), 2'b00};
                d_wdata = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                d_req = 1'b0;
            end
            @(negedge clk);
            e_en    = exp_if_gnt || exp_d_gnt;
            e_we    = exp_d_gnt && d_we;
            e_be    = (exp_d_gnt && d_we) ? d_be : 4'h0;
            e_addr  = exp_if_gnt ? if_addr : (exp_d_gnt ? d_addr : '0);
            e_wdata = exp_d_gnt ? d_wdata : '0;
            e_ird   = (m_owner == 1) ? m_rdata : '0;
            e_drd   = (m_owner == 2) ? m_rdata : '0;
            checks++;
            if (if_gnt !== exp_if_gnt || d_gnt !== exp_d_gnt) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d gnt=%b%b exp %b%b", c, if_gnt, d_gnt, exp_if_gnt, exp_d_gnt);
            end
            checks++;
            if (mem_en !== e_en || mem_we !== e_we || mem_be !== e_be ||
                mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rnd_mem c=%0d en=%b we=%b be=%h addr=%h wdata=%h exp %b %b %h %h %h",
                         c, mem_en, mem_we, mem_be, mem_addr, mem_wdata, e_en, e_we, e_be, e_addr, e_wdata);
            end
            checks++;
            if (if_rvalid !== (m_owner == 1) || d_rvalid !== (m_owner == 2) ||
                if_rdata !== e_ird || d_rdata !== e_drd) begin
                errors++;
                $display("FAIL rnd_rsp c=%0d rv=%b%b if_rdata=%h d_rdata=%h exp rv=%b%b %h %h",
                         c, if_rvalid, d_rvalid, if_rdata, d_rdata, m_owner == 1, m_owner == 2, e_ird, e_drd);
            end
            g_if = exp_if_gnt;
            g_d  = exp_d_gnt;
            next_cycle();
        end
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        #2;
        test_reset();
        test_fetch();
        test_store();
        test_priority_pattern();
        test_back_to_back();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
